// File: rtl/acc_reduce_if.sv
// Handshake and result bundle for acc_reduce: element stream in, reduction result out.
interface acc_reduce_if #(
    parameter int ACC_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] acc_out;
    logic [7:0]           result_out;
    logic                 overflow_out;
    logic [4:0]           count_out;

    // Producer/consumer side (drives elements, accepts results)
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, acc_out, result_out, overflow_out, count_out
    );

    // Reduction block side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, acc_out, result_out, overflow_out, count_out
    );
endinterface

// File: rtl/acc_reduce.sv
// acc_reduce: saturating signed sum of up to VECTOR_LEN 8-bit elements per vector.
// IDLE -> ACCUM while elements arrive, HOLD presents the result until it is taken.
// All outputs come straight from flops; the 8-bit saturated view is precomputed
// from the next accumulator value so it is registered alongside acc_out.
module acc_reduce #(
    parameter int VECTOR_LEN = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic         clock_in,
    input  logic         reset_in,
    input  logic         clear_in,
    acc_reduce_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [ACC_WIDTH-1:0] RES_MAX = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN = ~RES_MAX;
    localparam logic [4:0]                  VLEN    = 5'(VECTOR_LEN);

    state_t                      state_r, state_s;
    logic signed [ACC_WIDTH-1:0] acc_r, acc_s;
    logic [4:0]                  count_r, count_s;
    logic                        ovf_r, ovf_s;
    logic [7:0]                  result_r, result_s;
    logic                        in_ready_r, out_valid_r;

    logic signed [ACC_WIDTH-1:0] acc_base_s;
    logic [4:0]                  count_base_s;
    logic                        ovf_base_s;
    logic signed [ACC_WIDTH:0]   sum_s;
    logic signed [ACC_WIDTH-1:0] sat_sum_s;
    logic                        sat_hit_s;

    // Clamp a full-width value to the signed 8-bit range
    function automatic logic [7:0] sat8(input logic signed [ACC_WIDTH-1:0] v);
        if (v > RES_MAX) begin
            return 8'h7F;
        end else if (v < RES_MIN) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction

    // Saturating adder; a new vector starts from zero so IDLE needs no separate load path
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_base_s   = '0;
            count_base_s = 5'd0;
            ovf_base_s   = 1'b0;
        end else begin
            acc_base_s   = acc_r;
            count_base_s = count_r;
            ovf_base_s   = ovf_r;
        end
        sum_s = {acc_base_s[ACC_WIDTH-1], acc_base_s}
              + {{(ACC_WIDTH-7){bus.in_data[7]}}, bus.in_data};
        if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
            sat_sum_s = sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            sat_hit_s = 1'b1;
        end else begin
            sat_sum_s = sum_s[ACC_WIDTH-1:0];
            sat_hit_s = 1'b0;
        end
    end

    // Next-state and next-datapath values; clear_in outranks everything else
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        count_s = count_r;
        ovf_s   = ovf_r;
        if (clear_in) begin
            state_s = ST_IDLE;
            acc_s   = '0;
            count_s = 5'd0;
            ovf_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ACCUM: begin
                    if (bus.in_valid) begin
                        acc_s   = sat_sum_s;
                        count_s = count_base_s + 5'd1;
                        ovf_s   = ovf_base_s | sat_hit_s;
                        if ((count_s == VLEN) || bus.in_last) begin
                            state_s = ST_HOLD;
                        end else begin
                            state_s = ST_ACCUM;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        result_s = sat8(acc_s);
    end

    // State and output registers; handshake flags are decoded from the next state
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_r     <= ST_IDLE;
            acc_r       <= '0;
            count_r     <= 5'd0;
            ovf_r       <= 1'b0;
            result_r    <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            count_r     <= count_s;
            ovf_r       <= ovf_s;
            result_r    <= result_s;
            in_ready_r  <= (state_s != ST_HOLD);
            out_valid_r <= (state_s == ST_HOLD);
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.acc_out      = acc_r;
    assign bus.result_out   = result_r;
    assign bus.overflow_out = ovf_r;
    assign bus.count_out    = count_r;
endmodule

// File: tb/tb_acc_reduce.sv
// Testbench for acc_reduce: a default-width instance driven by directed and random
// stimulus against a transaction-level reference, plus a 9-bit instance for saturation.
module tb_acc_reduce;
    logic clock_in = 1'b0;
    logic reset_in;
    logic clear_a;
    logic clear_b;

    acc_reduce_if #(.ACC_WIDTH(16)) ia ();
    acc_reduce_if #(.ACC_WIDTH(9))  ib ();

    acc_reduce #(.VECTOR_LEN(4), .ACC_WIDTH(16)) dut_a (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .clear_in (clear_a),
        .bus      (ia.slave)
    );

    acc_reduce #(.VECTOR_LEN(4), .ACC_WIDTH(9)) dut_b (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .clear_in (clear_b),
        .bus      (ib.slave)
    );

    always #5 clock_in = ~clock_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: is a result being held, is a vector open, running sum/count/overflow
    bit m_hold, m_busy, m_ovf;
    int m_acc, m_cnt;

    logic [31:0] obs_a;
    logic [24:0] obs_b;
    assign obs_a = {ia.in_ready, ia.out_valid, ia.acc_out, ia.result_out, ia.overflow_out, ia.count_out};
    assign obs_b = {ib.in_ready, ib.out_valid, ib.acc_out, ib.result_out, ib.overflow_out, ib.count_out};

    function automatic logic [7:0] ref_sat8(input int v);
        if (v > 127) return 8'h7F;
        else if (v < -128) return 8'h80;
        else return v[7:0];
    endfunction

    function automatic logic [31:0] exp_a();
        int a;
        int c;
        a = m_acc;
        c = m_cnt;
        return {!m_hold, m_hold, a[15:0], ref_sat8(m_acc), m_ovf, c[4:0]};
    endfunction

    task automatic model_reset();
        m_hold = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_acc = 0; m_cnt = 0;
    endtask

    // One clock on instance A, then advance the reference by the same inputs
    task automatic cycle(input bit v, input logic [7:0] d, input bit last, input bit ordy, input bit clr);
        int s;
        ia.in_valid = v; ia.in_data = d; ia.in_last = last; ia.out_ready = ordy; clear_a = clr;
        @(posedge clock_in); #1;
        if (clr) begin
            model_reset();
        end else if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (v) begin
            if (!m_busy) begin m_acc = 0; m_cnt = 0; m_ovf = 1'b0; end
            s = m_acc + int'($signed(d));
            if (s > 32767) begin s = 32767; m_ovf = 1'b1; end
            else if (s < -32768) begin s = -32768; m_ovf = 1'b1; end
            m_acc = s;
            m_cnt = m_cnt + 1;
            if (m_cnt == 4 || last) begin m_hold = 1'b1; m_busy = 1'b0; end
            else m_busy = 1'b1;
        end
    endtask

    task automatic cycle_b(input bit v, input logic [7:0] d, input bit last, input bit ordy, input bit clr);
        ib.in_valid = v; ib.in_data = d; ib.in_last = last; ib.out_ready = ordy; clear_b = clr;
        @(posedge clock_in); #1;
    endtask

    task automatic test_reset();
        ia.in_valid = 1'b0; ia.in_data = 8'd0; ia.in_last = 1'b0; ia.out_ready = 1'b0; clear_a = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = 8'd0; ib.in_last = 1'b0; ib.out_ready = 1'b0; clear_b = 1'b0;
        reset_in = 1'b1;
        #22;
        n_cmp++;
        if (obs_a !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_a: got %h want %h", obs_a, 32'h8000_0000); end
        n_cmp++;
        if (obs_b !== 25'h100_0000) begin n_bad++; $display("FAIL reset_b: got %h want %h", obs_b, 25'h100_0000); end
        @(negedge clock_in);
        reset_in = 1'b0;
        model_reset();
        @(posedge clock_in); #1;
        n_cmp++;
        if (obs_a !== exp_a()) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs_a, exp_a()); end
    endtask

    task automatic test_basic();
        logic [7:0] v [4];
        v[0] = 8'd3; v[1] = 8'hFB; v[2] = 8'd10; v[3] = 8'd7;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, v[i], 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (obs_a !== exp_a()) begin n_bad++; $display("FAIL basic_step%0d: got %h want %h", i, obs_a, exp_a()); end
        end
        n_cmp++;
        if ({ia.out_valid, ia.acc_out, ia.result_out, ia.overflow_out, ia.count_out} !== {1'b1, 16'd15, 8'd15, 1'b0, 5'd4}) begin
            n_bad++; $display("FAIL basic_result: got acc=%0d res=%0d cnt=%0d ov=%b", $signed(ia.acc_out), $signed(ia.result_out), ia.count_out, ia.overflow_out);
        end
        cycle(1'b1, 8'd99, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ia.in_ready, ia.out_valid, ia.count_out} !== {1'b1, 1'b0, 5'd4}) begin
            n_bad++; $display("FAIL basic_handshake: got rdy=%b vld=%b cnt=%0d want 1 0 4", ia.in_ready, ia.out_valid, ia.count_out);
        end
    endtask

    task automatic test_saturate();
        cycle(1'b1, 8'd100, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'd100, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'd100, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'd0,   1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ia.out_valid, ia.acc_out, ia.result_out, ia.overflow_out} !== {1'b1, 16'd300, 8'd127, 1'b0}) begin
            n_bad++; $display("FAIL sat_pos: got acc=%0d res=%0d ov=%b want 300 127 0", $signed(ia.acc_out), $signed(ia.result_out), ia.overflow_out);
        end
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ia.out_valid, ia.acc_out, ia.result_out} !== {1'b1, 16'hFE00, 8'h80}) begin
            n_bad++; $display("FAIL sat_neg: got acc=%0d res=%0d want -512 -128", $signed(ia.acc_out), $signed(ia.result_out));
        end
        n_cmp++;
        if (obs_a !== exp_a()) begin n_bad++; $display("FAIL sat_neg_model: got %h want %h", obs_a, exp_a()); end
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_acc9();
        for (int i = 0; i < 4; i++) cycle_b(1'b1, 8'd127, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ib.out_valid, ib.acc_out, ib.result_out, ib.overflow_out, ib.count_out} !== {1'b1, 9'h0FF, 8'd127, 1'b1, 5'd4}) begin
            n_bad++; $display("FAIL acc9_result: got acc=%h res=%0d ov=%b cnt=%0d want 0ff 127 1 4", ib.acc_out, ib.result_out, ib.overflow_out, ib.count_out);
        end
        cycle_b(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ib.out_valid, ib.overflow_out} !== {1'b0, 1'b1}) begin
            n_bad++; $display("FAIL acc9_sticky: got vld=%b ov=%b want 0 1", ib.out_valid, ib.overflow_out);
        end
        cycle_b(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ib.acc_out, ib.overflow_out, ib.count_out} !== {9'd1, 1'b0, 5'd1}) begin
            n_bad++; $display("FAIL acc9_newvec: got acc=%h ov=%b cnt=%0d want 001 0 1", ib.acc_out, ib.overflow_out, ib.count_out);
        end
        cycle_b(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        cycle_b(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({ia.out_valid, ia.acc_out, ia.count_out} !== {1'b1, 16'd9, 5'd1}) begin
            n_bad++; $display("FAIL bp_single: got vld=%b acc=%0d cnt=%0d want 1 9 1", ia.out_valid, ia.acc_out, ia.count_out);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'd50, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({ia.in_ready, ia.out_valid, ia.result_out, ia.acc_out, ia.count_out} !== {1'b0, 1'b1, 8'd9, 16'd9, 5'd1}) begin
                n_bad++; $display("FAIL bp_hold%0d: got rdy=%b vld=%b res=%0d cnt=%0d want 0 1 9 1", i, ia.in_ready, ia.out_valid, ia.result_out, ia.count_out);
            end
        end
        cycle(1'b1, 8'd50, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ia.in_ready, ia.out_valid} !== 2'b10) begin
            n_bad++; $display("FAIL bp_handshake: got rdy=%b vld=%b want 1 0", ia.in_ready, ia.out_valid);
        end
        n_cmp++;
        if (obs_a !== exp_a()) begin n_bad++; $display("FAIL bp_handshake_model: got %h want %h", obs_a, exp_a()); end
        cycle(1'b1, 8'd50, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ia.in_ready, ia.out_valid, ia.acc_out, ia.count_out} !== {1'b1, 1'b0, 16'd50, 5'd1}) begin
            n_bad++; $display("FAIL bp_accept50: got acc=%0d cnt=%0d want 50 1", ia.acc_out, ia.count_out);
        end
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_clear();
        cycle(1'b1, 8'd11, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'd22, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'd33, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs_a !== 32'h8000_0000) begin n_bad++; $display("FAIL clear_mid: got %h want %h", obs_a, 32'h8000_0000); end
        cycle(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ia.acc_out, ia.count_out, ia.out_valid} !== {16'd5, 5'd1, 1'b0}) begin
            n_bad++; $display("FAIL clear_restart: got acc=%0d cnt=%0d want 5 1", ia.acc_out, ia.count_out);
        end
        cycle(1'b1, 8'd6, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs_a !== 32'h8000_0000) begin n_bad++; $display("FAIL clear_hold: got %h want %h", obs_a, 32'h8000_0000); end
    endtask

    task automatic test_random();
        bit v, last, ordy, clr;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            last = ($urandom_range(0, 3) == 0);
            ordy = ($urandom_range(0, 1) == 1);
            clr  = ($urandom_range(0, 31) == 0);
            d    = 8'($urandom);
            cycle(v, d, last, ordy, clr);
            n_cmp++;
            if (obs_a !== exp_a()) begin n_bad++; $display("FAIL random%0d: got %h want %h", i, obs_a, exp_a()); end
        end
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ia.out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre: got vld=%b want 1", ia.out_valid); end
        #2;
        reset_in = 1'b1;
        #1;
        n_cmp++;
        if (obs_a !== 32'h8000_0000) begin n_bad++; $display("FAIL areset_a: got %h want %h", obs_a, 32'h8000_0000); end
        n_cmp++;
        if (obs_b !== 25'h100_0000) begin n_bad++; $display("FAIL areset_b: got %h want %h", obs_b, 25'h100_0000); end
        @(negedge clock_in);
        reset_in = 1'b0;
        model_reset();
        cycle(1'b1, 8'd7, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({ia.in_ready, ia.acc_out, ia.count_out} !== {1'b1, 16'd7, 5'd1}) begin
            n_bad++; $display("FAIL areset_first: got acc=%0d cnt=%0d want 7 1", ia.acc_out, ia.count_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_acc9();
        test_backpressure();
        test_clear();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
